// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: configurable UART receiver with glitch rejection,
// parity/framing checks and a valid/ready word FIFO.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rx_serial,
  input  logic                           rx_ready,
  output logic                           rx_data_valid,
  output logic [DATA_BITS-1:0]           rx_data,
  output logic                           rx_parity_err,
  output logic                           rx_frame_err,
  output logic                           overrun,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 2;

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DB_M1   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_M1   = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic          ODD     = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic       sync1;
  logic       rx_s;
  logic [1:0] settle;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   par_err, par_err_n;
  logic                   frm_err, frm_err_n;
  logic                   armed, armed_n;
  logic                   push, push_n;

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic [WW-1:0] head;

  // Two-flop synchroniser; settle masks the reset-value ones it emits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      settle <= 2'b00;
    end else begin
      sync1  <= rx_serial;
      rx_s   <= sync1;
      settle <= {settle[0], 1'b1};
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      armed   <= 1'b0;
      push    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_err <= par_err_n;
      frm_err <= frm_err_n;
      armed   <= armed_n;
      push    <= push_n;
    end
  end

  // Receiver next-state: mid-bit sampling of start, data, parity, stop.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_err_n = par_err;
    frm_err_n = frm_err;
    armed_n   = armed;
    push_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (settle[1] && rx_s) armed_n = 1'b1;
        if (armed && !rx_s) begin
          state_n   = S_START;
          cnt_n     = '0;
          bit_cnt_n = '0;
          armed_n   = 1'b0;
        end
      end
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_n     = '0;
          par_err_n = 1'b0;
          frm_err_n = 1'b0;
          state_n   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_cnt == DB_M1) begin
            bit_cnt_n = '0;
            state_n   = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_PAR: begin
        if (cnt == FULL_M1) begin
          cnt_n     = '0;
          par_err_n = (^{shreg, rx_s}) ^ ODD;
          state_n   = S_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (!rx_s) frm_err_n = 1'b1;
          if (bit_cnt == SB_M1) begin
            bit_cnt_n = '0;
            state_n   = S_IDLE;
            push_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign full    = (count == DEPTH);
  assign do_pop  = rx_data_valid && rx_ready;
  assign do_push = push && (!full || do_pop);

  // FIFO pointers, occupancy and overrun pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: word plus its error flags.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {frm_err, par_err, shreg};
  end

  assign head          = mem[rd_ptr];
  assign rx_data_valid = (count != '0);
  assign rx_data       = rx_data_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_parity_err = rx_data_valid & head[DATA_BITS];
  assign rx_frame_err  = rx_data_valid & head[DATA_BITS+1];
  assign fifo_count    = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of uart_rx_fifo in 8N1,
// 7E1 and 8N2 configurations at 16 clocks per bit.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       rx_a = 1'b1, ready_a = 1'b0;
  logic       valid_a, perr_a, ferr_a, ovr_a;
  logic [7:0] data_a;
  logic [2:0] cnt_a;

  logic       rx_b = 1'b1, ready_b = 1'b0;
  logic       valid_b, perr_b, ferr_b, ovr_b;
  logic [6:0] data_b;
  logic [2:0] cnt_b;

  logic       rx_c = 1'b1, ready_c = 1'b0;
  logic       valid_c, perr_c, ferr_c, ovr_c;
  logic [7:0] data_c;
  logic [2:0] cnt_c;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (ovr_a === 1'b1) ovr_cnt++;

  uart_rx_fifo #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_a (
    .clk(clk), .reset(rst_n), .rx_serial(rx_a),
    .rx_ready(ready_a), .rx_data_valid(valid_a),
    .rx_data(data_a), .rx_parity_err(perr_a),
    .rx_frame_err(ferr_a), .overrun(ovr_a),
    .fifo_count(cnt_a)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_b (
    .clk(clk), .reset(rst_n), .rx_serial(rx_b),
    .rx_ready(ready_b), .rx_data_valid(valid_b),
    .rx_data(data_b), .rx_parity_err(perr_b),
    .rx_frame_err(ferr_b), .overrun(ovr_b),
    .fifo_count(cnt_b)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_c (
    .clk(clk), .reset(rst_n), .rx_serial(rx_c),
    .rx_ready(ready_c), .rx_data_valid(valid_c),
    .rx_data(data_c), .rx_parity_err(perr_c),
    .rx_frame_err(ferr_c), .overrun(ovr_c),
    .fifo_count(cnt_c)
  );

  task automatic drive_bits(input int which, input logic [15:0] v,
                            input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        0:       rx_a = v[i];
        1:       rx_b = v[i];
        default: rx_c = v[i];
      endcase
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    drive_bits(0, {6'd0, 1'b1, d, 1'b0}, 10);
  endtask

  task automatic pop(input int which);
    case (which)
      0:       ready_a = 1'b1;
      1:       ready_b = 1'b1;
      default: ready_c = 1'b1;
    endcase
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    ready_b = 1'b0;
    ready_c = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid_a !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", valid_a);
    end
    checks++;
    if (data_a !== 8'h00) begin
      errors++; $display("FAIL reset_data got %h exp 00", data_a);
    end
    checks++;
    if ({perr_a, ferr_a} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got %b exp 00", {perr_a, ferr_a});
    end
    checks++;
    if (ovr_a !== 1'b0) begin
      errors++; $display("FAIL reset_overrun got %b exp 0", ovr_a);
    end
    checks++;
    if (cnt_a !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", cnt_a);
    end
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_8n1_latency;
    int lat;
    lat = -1;
    fork
      send_a(8'h37);
      begin
        for (int k = 0; k < 300; k++) begin
          @(posedge clk);
          #1;
          if (valid_a === 1'b1) begin
            lat = k;
            break;
          end
        end
      end
    join
    checks++;
    if (lat !== 155) begin
      errors++; $display("FAIL latency got %0d exp 155", lat);
    end
    checks++;
    if (data_a !== 8'h37) begin
      errors++; $display("FAIL data_37 got %h exp 37", data_a);
    end
    checks++;
    if ({perr_a, ferr_a} !== 2'b00) begin
      errors++; $display("FAIL flags_37 got %b exp 00", {perr_a, ferr_a});
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (data_a !== 8'h37 || valid_a !== 1'b1) begin
      errors++; $display("FAIL hold_37 got %h/%b exp 37/1", data_a, valid_a);
    end
    pop(0);
    checks++;
    if (valid_a !== 1'b0 || cnt_a !== 3'd0) begin
      errors++; $display("FAIL pop_37 got %b/%0d exp 0/0", valid_a, cnt_a);
    end
  endtask

  task automatic test_parity;
    drive_bits(1, {6'd0, 1'b1, 1'b1, 7'h55, 1'b0}, 10);
    checks++;
    if (perr_b !== 1'b1) begin
      errors++; $display("FAIL par_bad got %b exp 1", perr_b);
    end
    checks++;
    if (data_b !== 7'h55) begin
      errors++; $display("FAIL par_bad_data got %h exp 55", data_b);
    end
    pop(1);
    drive_bits(1, {6'd0, 1'b1, 1'b0, 7'h55, 1'b0}, 10);
    checks++;
    if (perr_b !== 1'b0 || valid_b !== 1'b1) begin
      errors++; $display("FAIL par_ok got %b/%b exp 0/1", perr_b, valid_b);
    end
    checks++;
    if (data_b !== 7'h55 || ferr_b !== 1'b0) begin
      errors++; $display("FAIL par_ok_data got %h/%b exp 55/0", data_b, ferr_b);
    end
    pop(1);
  endtask

  task automatic test_frame_err;
    drive_bits(2, {6'd0, 1'b1, 8'hA3, 1'b0}, 10);
    rx_c = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rx_c = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    drive_bits(2, {5'd0, 2'b11, 8'h01, 1'b0}, 11);
    checks++;
    if (cnt_c !== 3'd2) begin
      errors++; $display("FAIL ferr_count got %0d exp 2", cnt_c);
    end
    checks++;
    if (data_c !== 8'hA3 || ferr_c !== 1'b1) begin
      errors++; $display("FAIL ferr_A3 got %h/%b exp a3/1", data_c, ferr_c);
    end
    pop(2);
    checks++;
    if (data_c !== 8'h01 || {perr_c, ferr_c} !== 2'b00) begin
      errors++; $display("FAIL ferr_next got %h/%b exp 01/00",
                         data_c, {perr_c, ferr_c});
    end
    pop(2);
    checks++;
    if (cnt_c !== 3'd0) begin
      errors++; $display("FAIL ferr_drain got %0d exp 0", cnt_c);
    end
  endtask

  task automatic test_glitch;
    rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (cnt_a !== 3'd0 || valid_a !== 1'b0) begin
      errors++; $display("FAIL glitch got %0d/%b exp 0/0", cnt_a, valid_a);
    end
    send_a(8'h5A);
    checks++;
    if (cnt_a !== 3'd1 || data_a !== 8'h5A) begin
      errors++; $display("FAIL glitch_after got %0d/%h exp 1/5a", cnt_a, data_a);
    end
    pop(0);
  endtask

  task automatic test_overrun;
    int base;
    logic [7:0] exp_d;
    base = ovr_cnt;
    for (int i = 0; i < 4; i++) send_a(8'h10 + 8'(i));
    checks++;
    if (cnt_a !== 3'd4 || ovr_cnt - base !== 0) begin
      errors++; $display("FAIL fill got %0d/%0d exp 4/0", cnt_a, ovr_cnt - base);
    end
    send_a(8'h14);
    checks++;
    if (cnt_a !== 3'd4) begin
      errors++; $display("FAIL ovr_count got %0d exp 4", cnt_a);
    end
    checks++;
    if (ovr_cnt - base !== 1) begin
      errors++; $display("FAIL ovr_pulse got %0d exp 1", ovr_cnt - base);
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'h10 + 8'(i);
      checks++;
      if (data_a !== exp_d) begin
        errors++; $display("FAIL drain_%0d got %h exp %h", i, data_a, exp_d);
      end
      pop(0);
    end
    checks++;
    if (cnt_a !== 3'd0) begin
      errors++; $display("FAIL drain_end got %0d exp 0", cnt_a);
    end
  endtask

  task automatic test_overrun_pop;
    int base;
    logic [7:0] exp_d;
    base = ovr_cnt;
    for (int i = 0; i < 4; i++) send_a(8'h10 + 8'(i));
    fork
      send_a(8'h14);
      begin
        repeat (155) @(posedge clk);
        #1;
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        ready_a = 1'b0;
      end
    join
    checks++;
    if (ovr_cnt - base !== 0) begin
      errors++; $display("FAIL popfull_ovr got %0d exp 0", ovr_cnt - base);
    end
    checks++;
    if (cnt_a !== 3'd4) begin
      errors++; $display("FAIL popfull_count got %0d exp 4", cnt_a);
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'h11 + 8'(i);
      checks++;
      if (data_a !== exp_d) begin
        errors++; $display("FAIL popfull_%0d got %h exp %h", i, data_a, exp_d);
      end
      pop(0);
    end
  endtask

  task automatic test_reset_midframe;
    send_a(8'h77);
    rx_a = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (48) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_a  = 1'b0;
    #1;
    checks++;
    if (cnt_a !== 3'd0 || valid_a !== 1'b0) begin
      errors++; $display("FAIL async_clear got %0d/%b exp 0/0", cnt_a, valid_a);
    end
    @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (cnt_a !== 3'd0) begin
      errors++; $display("FAIL low_release got %0d exp 0", cnt_a);
    end
    rx_a = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_a(8'h42);
    checks++;
    if (cnt_a !== 3'd1 || data_a !== 8'h42) begin
      errors++; $display("FAIL after_reset got %0d/%h exp 1/42", cnt_a, data_a);
    end
    pop(0);
  endtask

  initial begin
    test_reset();
    test_8n1_latency();
    test_parity();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_overrun_pop();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
